// File: rtl/y86_bus_pkg.sv
// Shared types and constants for the y86 bus memory responder.
package y86_bus_pkg;

    localparam int unsigned BUS_W = 32;

    localparam logic [BUS_W-1:0] CONS_ADDR_DEF = 32'h0000_0FFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_t;

endpackage

// File: rtl/y86_bus_mem_if.sv
// CPU-side memory bus: the core drives address/data/strobes, memory returns read data.
interface y86_bus_mem_if;
    import y86_bus_pkg::*;

    logic [BUS_W-1:0] bus_A;
    logic [BUS_W-1:0] bus_wdata;
    logic [BUS_W-1:0] bus_rdata;
    logic             bus_RE;
    logic             bus_WE;

    modport master (
        output bus_A,
        output bus_wdata,
        output bus_RE,
        output bus_WE,
        input  bus_rdata
    );

    modport slave (
        input  bus_A,
        input  bus_wdata,
        input  bus_RE,
        input  bus_WE,
        output bus_rdata
    );

endinterface

// File: rtl/y86_byte_ram.sv
// Byte-wide RAM with a 4-lane little-endian read/write port and a 1-byte loader port.
// Lane addresses wrap modulo the RAM size, so unaligned words are legal.
module y86_byte_ram
    import y86_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BUS_W-1:0]  rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BUS_W-1:0]  wr_data,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data
);

    logic [7:0] mem_q [0:(1<<ADDR_W)-1];

    // Combinational word read: lane i comes from byte rd_addr+i.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < 4; i++) begin
            rd_data[8*i +: 8] = mem_q[rd_addr + ADDR_W'(i)];
        end
    end

    // Storage update; the two write sources are mutually exclusive by construction.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end else if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[wr_addr + ADDR_W'(i)] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/y86_bus_mem.sv
// Memory target for the y86_seq core: CPU reads/writes, serial program loader,
// console output register, saturating access counters and a sticky error flag.
module y86_bus_mem
    import y86_bus_pkg::*;
#(
    parameter int unsigned      ADDR_W    = 12,
    parameter logic [BUS_W-1:0] CONS_ADDR = CONS_ADDR_DEF,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    y86_bus_mem_if.slave     bus,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [7:0]       ld_byte,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             cpu_hold,
    output logic             cons_valid,
    output logic [7:0]       cons_data,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count,
    output logic             err
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              cons_valid_q, cons_valid_d;
    logic [7:0]        cons_data_q, cons_data_d;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic              err_q, err_d;

    logic              ld_wr;
    logic              in_idle;
    logic              addr_hi_bad;
    logic              any_acc;
    logic              rd_ok;
    logic              wr_ok;
    logic              is_cons;
    logic              ram_we;
    logic [BUS_W-1:0]  ram_rdata;

    // Loader FSM: IDLE waits for ld_start, LOAD streams bytes, DONE holds the CPU one more cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ld_wr   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ld_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    ld_wr = 1'b1;
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (ld_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // CPU access qualification, console capture, counters and error detection.
    always_comb begin
        in_idle     = (state_q == IDLE);
        addr_hi_bad = |bus.bus_A[BUS_W-1:ADDR_W];
        any_acc     = bus.bus_RE | bus.bus_WE;
        rd_ok       = bus.bus_RE && !bus.bus_WE && in_idle && !addr_hi_bad;
        wr_ok       = bus.bus_WE && !bus.bus_RE && in_idle && !addr_hi_bad;
        is_cons     = (bus.bus_A == CONS_ADDR);
        ram_we      = wr_ok && !is_cons;

        cons_valid_d = 1'b0;
        cons_data_d  = cons_data_q;
        if (wr_ok && is_cons) begin
            cons_valid_d = 1'b1;
            cons_data_d  = bus.bus_wdata[7:0];
        end

        rd_count_d = rd_ok ? sat_inc(rd_count_q) : rd_count_q;
        wr_count_d = wr_ok ? sat_inc(wr_count_q) : wr_count_q;

        err_d = err_q
              | (bus.bus_RE && bus.bus_WE)
              | (any_acc && !in_idle)
              | (any_acc && addr_hi_bad);
    end

    // Control and status registers; RAM contents are deliberately left out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cons_valid_q <= 1'b0;
            cons_data_q  <= '0;
            rd_count_q   <= '0;
            wr_count_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cons_valid_q <= cons_valid_d;
            cons_data_q  <= cons_data_d;
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
            err_q        <= err_d;
        end
    end

    y86_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rd_addr (bus.bus_A[ADDR_W-1:0]),
        .rd_data (ram_rdata),
        .wr_en   (ram_we),
        .wr_addr (bus.bus_A[ADDR_W-1:0]),
        .wr_data (bus.bus_wdata),
        .ld_en   (ld_wr),
        .ld_addr (ptr_q),
        .ld_data (ld_byte)
    );

    assign bus.bus_rdata = rd_ok ? ram_rdata : '0;
    assign ld_ready      = (state_q == LOAD);
    assign cpu_hold      = (state_q != IDLE);
    assign cons_valid    = cons_valid_q;
    assign cons_data     = cons_data_q;
    assign rd_count      = rd_count_q;
    assign wr_count      = wr_count_q;
    assign err           = err_q;

endmodule

// File: tb/tb_y86_bus_mem.sv
// Directed + randomized bench for y86_bus_mem against a byte-array reference model.
module tb_y86_bus_mem;

    localparam int MEM_N = 4096;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [31:0] CONS = 32'h0000_0FFC;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ld_start = 1'b0;
    logic             ld_valid = 1'b0;
    logic [7:0]       ld_byte = 8'h00;
    logic             ld_last = 1'b0;
    logic             ld_ready;
    logic             cpu_hold;
    logic             cons_valid;
    logic [7:0]       cons_data;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] wr_count;
    logic             err;

    y86_bus_mem_if bus_if ();

    y86_bus_mem #(
        .ADDR_W    (12),
        .CONS_ADDR (CONS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .cpu_hold   (cpu_hold),
        .cons_valid (cons_valid),
        .cons_data  (cons_data),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [7:0] ref_mem [MEM_N];
    logic [7:0] ld_buf  [MEM_N];
    int         ref_rd;
    int         ref_wr;
    logic       ref_err;
    logic [7:0] ref_cons;
    int         ref_ptr;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[(a + i) % MEM_N];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_rd_count"}, 32'(rd_count), 32'(ref_rd));
        check({tag, "_wr_count"}, 32'(wr_count), 32'(ref_wr));
        check({tag, "_err"}, 32'(err), 32'(ref_err));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #2;
        ref_rd = 0; ref_wr = 0; ref_err = 1'b0; ref_cons = 8'h00;
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_cons_valid"}, 32'(cons_valid), 32'd0);
        check({tag, "_cons_data"}, 32'(cons_data), 32'd0);
        check_status(tag);
        rst = 1'b1;
        tick();
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input string tag);
        bus_if.bus_A = a; bus_if.bus_wdata = d; bus_if.bus_WE = 1'b1;
        tick();
        bus_if.bus_WE = 1'b0;
        if (ref_wr < CNT_MAX) ref_wr++;
        if (a == CONS) begin
            ref_cons = d[7:0];
            check({tag, "_cons_valid"}, 32'(cons_valid), 32'd1);
        end else begin
            for (int i = 0; i < 4; i++) ref_mem[(int'(a) + i) % MEM_N] = d[8*i +: 8];
            check({tag, "_cons_valid"}, 32'(cons_valid), 32'd0);
        end
        check({tag, "_cons_data"}, 32'(cons_data), 32'(ref_cons));
    endtask

    task automatic cpu_read(input logic [31:0] a, input string tag, output logic [31:0] obs);
        bus_if.bus_A = a; bus_if.bus_RE = 1'b1;
        #1;
        obs = bus_if.bus_rdata;
        check(tag, obs, ref_word(int'(a)));
        tick();
        bus_if.bus_RE = 1'b0;
        if (ref_rd < CNT_MAX) ref_rd++;
    endtask

    // Streams ld_buf[0..n-1]; optionally injects a stray ld_start, a CPU write or a CPU read.
    task automatic load_bytes(input int n, input bit last, input int start_at,
                              input int wr_at, input int rd_at, input string tag);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        ref_ptr = 0;
        check({tag, "_ready_on"}, 32'(ld_ready), 32'd1);
        check({tag, "_hold_on"}, 32'(cpu_hold), 32'd1);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_byte  = ld_buf[i];
            ld_last  = last && (i == n - 1);
            ld_start = (i == start_at);
            if (i == wr_at) begin
                bus_if.bus_A = 32'd8; bus_if.bus_wdata = $urandom; bus_if.bus_WE = 1'b1;
            end
            if (i == rd_at) begin
                bus_if.bus_A = 32'd0; bus_if.bus_RE = 1'b1;
                #1;
                check({tag, "_rd_in_load"}, bus_if.bus_rdata, 32'd0);
            end
            if (i == 0 || i == n - 1)
                check({tag, "_ready_byte"}, 32'(ld_ready), 32'd1);
            tick();
            ref_mem[ref_ptr] = ld_buf[i];
            ref_ptr = (ref_ptr + 1) % MEM_N;
            if (i == wr_at || i == rd_at) ref_err = 1'b1;
            bus_if.bus_WE = 1'b0; bus_if.bus_RE = 1'b0;
        end
        ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
        if (last) begin
            check({tag, "_done_ready"}, 32'(ld_ready), 32'd0);
            check({tag, "_done_hold"}, 32'(cpu_hold), 32'd1);
            tick();
            check({tag, "_idle_hold"}, 32'(cpu_hold), 32'd0);
            check({tag, "_idle_ready"}, 32'(ld_ready), 32'd0);
        end else begin
            check({tag, "_still_ready"}, 32'(ld_ready), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] d;

        bus_if.bus_A = '0; bus_if.bus_wdata = '0; bus_if.bus_RE = 1'b0; bus_if.bus_WE = 1'b0;
        ref_rd = 0; ref_wr = 0; ref_err = 1'b0; ref_cons = 8'h00; ref_ptr = 0;
        tick();
        tick();
        do_reset("init");

        // Fill the whole RAM so every later read has a known reference.
        for (int i = 0; i < MEM_N; i++) ld_buf[i] = 8'($urandom);
        load_bytes(MEM_N, 1'b1, -1, -1, -1, "full");

        // Loader bytes outside LOAD are ignored and raise no error.
        ld_valid = 1'b1; ld_byte = ~ref_mem[0]; ld_last = 1'b1;
        tick(); tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("idle_ldvalid_hold", 32'(cpu_hold), 32'd0);
        cpu_read(32'd0, "idle_ldvalid_rd", r);
        check_status("idle_ldvalid");

        // Load 01..06 with a stray ld_start mid-stream.
        for (int i = 0; i < 6; i++) ld_buf[i] = 8'(i + 1);
        load_bytes(6, 1'b1, 3, -1, -1, "six");
        cpu_read(32'd1, "six_rd1", r);
        check("six_rd1_const", r, 32'h0504_0302);

        // Wrap-around write and read.
        do_reset("pre_wrap");
        cpu_write(32'h0000_0FFE, 32'hAABB_CCDD, "wrap_wr");
        cpu_read(32'h0000_0FFE, "wrap_rd", r);
        check("wrap_rd_const", r, 32'hAABB_CCDD);
        check("wrap_wr_count", 32'(wr_count), 32'd1);
        check("wrap_rd_count", 32'(rd_count), 32'd1);
        cpu_read(32'd0, "wrap_rd0", r);
        check("wrap_rd0_const", r, 32'h0403_AABB);

        // Console write: one-cycle pulse, RAM untouched.
        cpu_write(CONS, 32'h0000_0041, "cons_wr");
        check("cons_data_41", 32'(cons_data), 32'h41);
        tick();
        check("cons_pulse_end", 32'(cons_valid), 32'd0);
        check("cons_data_hold", 32'(cons_data), 32'h41);
        cpu_read(CONS, "cons_rd_ram", r);
        check_status("cons");

        // Random legal traffic; counters saturate at the narrow bench width.
        for (int k = 0; k < 150; k++) begin
            a = 32'($urandom_range(0, MEM_N - 1));
            if ($urandom_range(0, 15) == 0) a = CONS;
            d = $urandom;
            if ($urandom_range(0, 1) == 0) cpu_write(a, d, "rnd_wr");
            else cpu_read(a, "rnd_rd", r);
        end
        check_status("rnd");
        check("rnd_rd_sat", 32'(rd_count), 32'(CNT_MAX));

        // Simultaneous RE and WE is dropped and flagged.
        do_reset("pre_both");
        bus_if.bus_A = 32'd0; bus_if.bus_wdata = ~ref_word(0);
        bus_if.bus_RE = 1'b1; bus_if.bus_WE = 1'b1;
        tick();
        bus_if.bus_RE = 1'b0; bus_if.bus_WE = 1'b0;
        ref_err = 1'b1;
        check_status("both");
        cpu_read(32'd0, "both_rd0", r);

        // Out-of-range address: zero data, no count, no RAM update.
        do_reset("pre_hi");
        bus_if.bus_A = 32'h0001_0000; bus_if.bus_RE = 1'b1;
        #1;
        check("hi_rdata", bus_if.bus_rdata, 32'd0);
        tick();
        bus_if.bus_RE = 1'b0;
        bus_if.bus_A = 32'h0001_0000; bus_if.bus_wdata = ~ref_word(0); bus_if.bus_WE = 1'b1;
        tick();
        bus_if.bus_WE = 1'b0;
        ref_err = 1'b1;
        check_status("hi");
        cpu_read(32'd0, "hi_rd0", r);

        // CPU accesses during LOAD are dropped; the byte stream is unaffected.
        do_reset("pre_acc_load");
        for (int i = 0; i < 5; i++) ld_buf[i] = 8'($urandom);
        load_bytes(5, 1'b1, -1, 1, 2, "acc_load");
        check_status("acc_load");
        cpu_read(32'd0, "acc_load_rd0", r);
        cpu_read(32'd8, "acc_load_rd8", r);

        // Reset in the middle of a load keeps the bytes already written.
        do_reset("pre_mid");
        for (int i = 0; i < 3; i++) ld_buf[i] = 8'($urandom);
        load_bytes(3, 1'b0, -1, -1, -1, "mid");
        do_reset("mid_rst");
        cpu_read(32'd0, "mid_rd0", r);
        check("mid_rd0_bytes", {8'h00, r[23:0]}, {8'h00, ld_buf[2], ld_buf[1], ld_buf[0]});
        check_status("mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
